// File: rtl/ram_word_ctrl.sv
// ram_word_ctrl: initiator-side controller for a single-port byte RAM with
// a 1-cycle registered read latency and separate read/write enables.
//
// A word request (BEATS * DATA_WIDTH bits) is accepted over a valid/ready
// handshake. It is split into BEATS sequential RAM accesses at base, base+1,
// and so on. Read beats are assembled little-endian, so beat 0 is the least
// significant byte. Exactly one response is returned per request, and only
// one request is in flight at a time.
//
// Optional feature (macro RAM_WORD_CTRL_WMASK_EN):
//   This adds input req_wmask[BEATS], which is latched at acceptance.
//   A store beat whose mask bit is 0 still takes its cycle, but
//   ram_write_enable stays low for that beat. Loads ignore the mask.
//
// Ports:
//   clk, rst            clock (posedge), asynchronous active-high reset
//   req_valid/ready     request handshake; req_ready = idle && !rst
//   req_write           1 = store, 0 = load
//   req_addr            byte address of beat 0
//   req_wdata           store data, beat k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_wmask           (optional) per-beat store enable
//   rsp_valid/ready     response handshake
//   rsp_rdata           load data; 0 for stores and errors
//   rsp_err             request rejected as out of range
//   ram_*               registered RAM-side address, data and enables
module ram_word_ctrl #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BEATS      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic [BEATS*DATA_WIDTH-1:0] req_wdata,
`ifdef RAM_WORD_CTRL_WMASK_EN
  input  logic [BEATS-1:0]            req_wmask,
`endif
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [BEATS*DATA_WIDTH-1:0] rsp_rdata,
  output logic                        rsp_err,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_data_in,
  output logic                        ram_read_enable,
  output logic                        ram_write_enable,
  input  logic [DATA_WIDTH-1:0]       ram_data_out
);

  localparam int unsigned WordWidth = BEATS * DATA_WIDTH;
  localparam int unsigned CntWidth  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CntWidth-1:0]   LastBeat = CntWidth'(BEATS - 1);
  localparam logic [ADDR_WIDTH:0]   BeatSpan = (ADDR_WIDTH + 1)'(BEATS - 1);
  localparam logic [ADDR_WIDTH:0]   DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrite = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StResp  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [WordWidth-1:0]  wdata_q, wdata_d;
  logic [WordWidth-1:0]  rbuf_q, rbuf_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [WordWidth-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  ram_re_q, ram_re_d;
  logic                  ram_we_q, ram_we_d;

  // Range check is one bit wider than the address so base+BEATS-1 cannot wrap.
  logic [ADDR_WIDTH:0]   last_addr;
  logic                  range_err;
  assign last_addr = {1'b0, req_addr} + BeatSpan;
  assign range_err = (last_addr >= DepthLim);

  // Read data enters at the top and shifts down. After BEATS captures,
  // beat 0 sits in the least significant byte.
  logic [WordWidth-1:0]  rbuf_shift;
  assign rbuf_shift = (rbuf_q >> DATA_WIDTH)
                    | (WordWidth'(ram_data_out) << (WordWidth - DATA_WIDTH));

  // Per-beat write enables. The mask is shifted alongside the store data.
  logic first_we;
  logic next_we;
`ifdef RAM_WORD_CTRL_WMASK_EN
  logic [BEATS-1:0] wmask_q, wmask_d;
  assign first_we = req_wmask[0];
  assign next_we  = wmask_q[0];
`else
  assign first_we = 1'b1;
  assign next_we  = 1'b1;
`endif

  assign req_ready        = (state_q == StIdle) && !rst;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_err          = rsp_err_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign ram_addr         = ram_addr_q;
  assign ram_data_in      = ram_din_q;
  assign ram_read_enable  = ram_re_q;
  assign ram_write_enable = ram_we_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_re_d    = 1'b0;
    ram_we_d    = 1'b0;
`ifdef RAM_WORD_CTRL_WMASK_EN
    wmask_d     = wmask_q;
`endif

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d  = '0;
          rbuf_d = '0;
          if (range_err) begin
            // Rejected requests never touch the RAM.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_write) begin
            state_d    = StWrite;
            ram_addr_d = req_addr;
            ram_din_d  = req_wdata[DATA_WIDTH-1:0];
            ram_we_d   = first_we;
            wdata_d    = req_wdata >> DATA_WIDTH;
`ifdef RAM_WORD_CTRL_WMASK_EN
            wmask_d    = req_wmask >> 1;
`endif
          end else begin
            state_d    = StRead;
            ram_addr_d = req_addr;
            ram_re_d   = 1'b1;
          end
        end
      end

      StWrite: begin
        if (cnt_q == LastBeat) begin
          state_d     = StResp;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          ram_addr_d = ram_addr_q + 1'b1;
          ram_din_d  = wdata_q[DATA_WIDTH-1:0];
          ram_we_d   = next_we;
          wdata_d    = wdata_q >> DATA_WIDTH;
`ifdef RAM_WORD_CTRL_WMASK_EN
          wmask_d    = wmask_q >> 1;
`endif
        end
      end

      StRead: begin
        // Data for the beat issued in the previous cycle is on ram_data_out now.
        if (cnt_q != '0) begin
          rbuf_d = rbuf_shift;
        end
        if (cnt_q == LastBeat) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          ram_addr_d = ram_addr_q + 1'b1;
          ram_re_d   = 1'b1;
        end
      end

      StDrain: begin
        // This state only collects the final beat. No RAM access is issued.
        rbuf_d      = rbuf_shift;
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rbuf_shift;
      end

      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end

      default: begin
        state_d     = StIdle;
        cnt_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
    end
  end

`ifdef RAM_WORD_CTRL_WMASK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wmask_q <= '0;
    end else begin
      wmask_q <= wmask_d;
    end
  end
`endif

endmodule

// File: tb/tb_ram_word_ctrl.sv
// Directed testbench for ram_word_ctrl at default parameters. It includes a
// behavioural byte RAM with a 1-cycle registered read.
// The mask test is compiled in only when RAM_WORD_CTRL_WMASK_EN is defined.
module tb_ram_word_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [4:0]  ram_addr;
  logic [7:0]  ram_data_in;
  logic        ram_read_enable;
  logic        ram_write_enable;
  logic [7:0]  ram_data_out;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_word_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
`ifdef RAM_WORD_CTRL_WMASK_EN
    .req_wmask        (req_wmask),
`endif
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .ram_addr         (ram_addr),
    .ram_data_in      (ram_data_in),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out)
  );

  // RAM model plus enable activity counters.
  logic [7:0] mem [0:31];
  int we_cnt   = 0;
  int re_cnt   = 0;
  int both_cnt = 0;

  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_addr] <= ram_data_in;
    if (ram_read_enable)  ram_data_out  <= mem[ram_addr];
    if (ram_write_enable) we_cnt   <= we_cnt + 1;
    if (ram_read_enable)  re_cnt   <= re_cnt + 1;
    if (ram_write_enable && ram_read_enable) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in cycle 0 and returns the cycle in which rsp_valid
  // first rose. The response is consumed with rsp_ready=1.
  task automatic do_req(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                        input logic [3:0] mask, output int lat, output logic [31:0] rd,
                        output logic err, output logic [7:0] we_pat);
    we_pat    = '0;
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_wmask = mask;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (ram_write_enable) we_pat[lat-1] = 1'b1;
      tick();
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 1'b0, 1'b1);
    rd  = rsp_rdata;
    err = rsp_err;
    tick();
    check("rsp_drop", rsp_valid, 1'b0);
    check("back_idle", req_ready, 1'b1);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        err;
  logic [7:0]  pat;
  logic [31:0] held;
  int          seen;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = 4'hf;
    rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    tick();
    tick();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_outputs", {rsp_valid, rsp_err, rsp_rdata, ram_addr, ram_data_in,
                          ram_read_enable, ram_write_enable}, '0);
    rst = 1'b0;
    tick();
    check("rel_req_ready", req_ready, 1'b1);

    // Abort a store with reset in the middle of a cycle while req_valid stays high.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 5'd8;
    req_wdata = 32'h55667788;
    tick();
    check("abort_we_on", ram_write_enable, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", {rsp_valid, rsp_err, rsp_rdata, ram_addr, ram_data_in,
                             ram_read_enable, ram_write_enable}, '0);
    check("midrst_req_ready", req_ready, 1'b0);
    tick();
    req_valid = 1'b0;
    rst       = 1'b0;
    tick();
    check("midrst_release", req_ready, 1'b1);

    // Store 0xDEADBEEF at address 4, then load it back.
    we_cnt = 0;
    do_req(1'b1, 5'd4, 32'hDEADBEEF, 4'hf, lat, rd, err, pat);
    check("st_lat", lat, 5);
    check("st_err", err, 1'b0);
    check("st_rdata", rd, 32'h0);
    check("st_mem", {mem[7], mem[6], mem[5], mem[4]}, 32'hDEADBEEF);
    check("st_we_pat", pat, 8'h0f);
    check("st_we_cnt", we_cnt, 4);
    do_req(1'b0, 5'd4, 32'h0, 4'hf, lat, rd, err, pat);
    check("ld_lat", lat, 6);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err", err, 1'b0);

    // An out-of-range request must never enable the RAM.
    we_cnt = 0;
    re_cnt = 0;
    do_req(1'b0, 5'd13, 32'h0, 4'hf, lat, rd, err, pat);
    check("oor_lat", lat, 1);
    check("oor_err", err, 1'b1);
    check("oor_rdata", rd, 32'h0);
    check("oor_no_en", we_cnt + re_cnt, 0);
    do_req(1'b1, 5'd12, 32'h01020304, 4'hf, lat, rd, err, pat);
    check("a12_st_err", err, 1'b0);
    do_req(1'b0, 5'd12, 32'h0, 4'hf, lat, rd, err, pat);
    check("a12_ld_rdata", rd, 32'h01020304);
    check("a12_ld_err", err, 1'b0);

    // Hold rsp_ready low for 3 cycles under backpressure.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'd4;
    tick();
    req_valid = 1'b0;
    seen = 0;
    while (!rsp_valid && seen < 20) begin
      tick();
      seen++;
    end
    check("bp_seen", rsp_valid, 1'b1);
    held = rsp_rdata;
    check("bp_rdata", held, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid_hold", rsp_valid, 1'b1);
      check("bp_rdata_hold", rsp_rdata, held);
      check("bp_ready_low", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", rsp_valid, 1'b0);
    check("bp_release_idle", req_ready, 1'b1);

    // Reset in cycle 3 of a load drops that response.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'd4;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      if (rsp_valid) seen++;
    end
    check("rst_load_dropped", seen, 0);
    do_req(1'b0, 5'd4, 32'h0, 4'hf, lat, rd, err, pat);
    check("post_rst_lat", lat, 6);
    check("post_rst_rdata", rd, 32'hDEADBEEF);

`ifdef RAM_WORD_CTRL_WMASK_EN
    do_req(1'b1, 5'd0, 32'h11223344, 4'hf, lat, rd, err, pat);
    do_req(1'b1, 5'd0, 32'hAABBCCDD, 4'b0101, lat, rd, err, pat);
    check("mask_lat", lat, 5);
    check("mask_we_pat", pat, 8'h05);
    do_req(1'b0, 5'd0, 32'h0, 4'b0000, lat, rd, err, pat);
    check("mask_ld_rdata", rd, 32'h11BB33DD);
`endif

    check("we_re_overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
